// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions.
// Widths, PC step, reset PC and the fetch FSM state encoding.
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_RESP,
    FS_DRAIN,
    FS_HOLD
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
// Async active-low reset to RESET_PC, load-enabled update.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] pc_d_i,
  output logic [ADDR_W-1:0] pc_q_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (ld_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch: PC, single-outstanding imem reads, output buffer.
// FETCH_ALIGN_CHECK_EN: misaligned redirects latch fetch_misalign and halt.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_misalign
);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pc_ld;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic               mis_q, mis_d;

  logic               redir;
  logic               bad;
  logic [ADDR_W-1:0]  rpc;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst),
    .ld_i   (pc_ld),
    .pc_d_i (pc_d),
    .pc_q_o (pc_q)
  );

  // Once halted on a misaligned target, further redirects are ignored.
  assign redir = redirect_valid && !mis_q;
  assign bad   = ALIGN_CHK && (redirect_pc[1:0] != 2'b00);
  assign rpc   = word_align(redirect_pc);

  always_comb begin
    state_d = state_q;
    pc_ld   = 1'b0;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    mis_d   = mis_q;

    if (redir && bad) begin
      mis_d = 1'b1;
      ipc_d = redirect_pc;
    end

    unique case (state_q)
      FS_IDLE: begin
        if (redir) begin
          if (!bad) begin
            state_d = FS_REQ;
            pc_ld   = 1'b1;
            pc_d    = rpc;
          end
        end else if (!mis_q) begin
          state_d = FS_REQ;
          pc_ld   = 1'b1;
          pc_d    = RESET_PC;
        end
      end
      FS_REQ: begin
        if (redir) begin
          if (imem_gnt) begin
            tgt_d   = rpc;
            state_d = FS_DRAIN;
          end else if (bad) begin
            state_d = FS_IDLE;
          end else begin
            pc_ld = 1'b1;
            pc_d  = rpc;
          end
        end else if (imem_gnt) begin
          state_d = FS_RESP;
        end
      end
      FS_RESP: begin
        if (redir) begin
          if (!imem_rvalid) begin
            tgt_d   = rpc;
            state_d = FS_DRAIN;
          end else if (bad) begin
            state_d = FS_IDLE;
          end else begin
            state_d = FS_REQ;
            pc_ld   = 1'b1;
            pc_d    = rpc;
          end
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = FS_HOLD;
        end
      end
      FS_DRAIN: begin
        if (redir) begin
          tgt_d = rpc;
        end
        if (imem_rvalid) begin
          if (mis_d) begin
            state_d = FS_IDLE;
          end else begin
            state_d = FS_REQ;
            pc_ld   = 1'b1;
            pc_d    = tgt_d;
          end
        end
      end
      FS_HOLD: begin
        if (redir) begin
          valid_d = 1'b0;
          if (bad) begin
            state_d = FS_IDLE;
          end else begin
            state_d = FS_REQ;
            pc_ld   = 1'b1;
            pc_d    = rpc;
          end
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = FS_REQ;
          pc_ld   = 1'b1;
          pc_d    = pc_q + PC_STEP;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase

    req_d = (state_d == FS_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_IDLE;
      tgt_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = word_align(pc_q);
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misalign = mis_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: imem responder, scoreboard of requests/deliveries.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] ipc2;
  logic        mis2;

  int          n_chk = 0;
  int          n_pass = 0;
  int          lat = 1;
  logic        gnt_on = 1'b1;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] wrap_q[$];

  always #5 clk = ~clk;

  assign imem_gnt = gnt_on;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  fetch_pc_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_gnt       (1'b1),
    .imem_rvalid    (rvalid2),
    .imem_rdata     (rdata2),
    .instr_valid    (valid2),
    .instr_ready    (1'b1),
    .instr          (instr2),
    .instr_pc       (ipc2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .fetch_misalign (mis2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic take();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 50) begin
      step();
      n++;
    end
    chk("wait_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic push_deliv(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(mem(pc));
  endtask

  // imem model: one response `lat` cycles after each accept
  initial begin : mem_model
    int cnt;
    logic busy;
    logic [31:0] pa;
    cnt = 0;
    busy = 1'b0;
    pa = '0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    rvalid2 = 1'b0;
    rdata2 = 32'h0000_0013;
    forever begin
      logic pend2;
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem(pa);
          busy = 1'b0;
        end
      end
      if (rst && imem_req && imem_gnt) begin
        busy = 1'b1;
        cnt = lat;
        pa = imem_addr;
      end
      rvalid2 = pend2;
      pend2 = rst && req2;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst && imem_req && imem_gnt) begin
        chk("sb_req_expected", {31'b0, exp_addr_q.size() != 0}, 32'd1);
        if (exp_addr_q.size() != 0)
          chk("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (rst && instr_valid && instr_ready) begin
        chk("sb_instr_expected", {31'b0, exp_pc_q.size() != 0}, 32'd1);
        if (exp_pc_q.size() != 0) begin
          chk("deliv_pc", instr_pc, exp_pc_q.pop_front());
          chk("deliv_instr", instr, exp_ins_q.pop_front());
        end
      end
      if (rst && req2 && wrap_q.size() < 4) wrap_q.push_back(addr2);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_mis", {31'b0, fetch_misalign}, 32'd0);
    chk("rst_wrap_addr", addr2, 32'hFFFF_FFFC);

    // first fetch
    exp_addr_q.push_back(32'h0);
    push_deliv(32'h0);
    exp_addr_q.push_back(32'h4);
    rst = 1'b1;
    n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("first_req", {31'b0, imem_req}, 32'd1);
    step();
    chk("lat_resp", {31'b0, instr_valid}, 32'd0);
    step();
    chk("lat_hold", {31'b0, instr_valid}, 32'd1);
    take();
    chk("next_addr", imem_addr, 32'h4);
    chk("next_req", {31'b0, imem_req}, 32'd1);

    // backpressure
    push_deliv(32'h4);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_instr", instr, mem(32'h4));
      chk("bp_pc", instr_pc, 32'h4);
      chk("bp_noreq", {31'b0, imem_req}, 32'd0);
      step();
    end
    exp_addr_q.push_back(32'h8);
    take();
    chk("bp_next_addr", imem_addr, 32'h8);

    // redirect while waiting for rvalid
    lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    lat = 1;
    chk("drain_noreq", {31'b0, imem_req}, 32'd0);
    exp_addr_q.push_back(32'h100);
    push_deliv(32'h100);
    wait_valid();
    gnt_on = 1'b0;
    take();

    // redirect in REQ without gnt
    chk("nognt_addr", imem_addr, 32'h104);
    chk("nognt_req", {31'b0, imem_req}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("redir_req_addr", imem_addr, 32'h200);
    chk("redir_req_req", {31'b0, imem_req}, 32'd1);

    // redirect in RESP then again in DRAIN
    lat = 3;
    gnt_on = 1'b1;
    exp_addr_q.push_back(32'h200);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    step();
    redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    lat = 1;
    exp_addr_q.push_back(32'h400);
    push_deliv(32'h400);
    wait_valid();
    gnt_on = 1'b0;
    take();

    // misaligned redirect
    chk("pre_mis_addr", imem_addr, 32'h404);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag", {31'b0, fetch_misalign}, 32'd1);
    chk("mis_ipc", instr_pc, 32'h102);
    chk("mis_noreq", {31'b0, imem_req}, 32'd0);
    gnt_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mis_halt_req", {31'b0, imem_req}, 32'd0);
      chk("mis_sticky", {31'b0, fetch_misalign}, 32'd1);
    end
`else
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req", {31'b0, imem_req}, 32'd1);
    chk("mis_flag", {31'b0, fetch_misalign}, 32'd0);
    exp_addr_q.push_back(32'h100);
    push_deliv(32'h100);
    gnt_on = 1'b1;
    wait_valid();
    gnt_on = 1'b0;
    take();
`endif

    step();
    chk("sb_req_left", exp_addr_q.size(), 32'd0);
    chk("sb_instr_left", exp_pc_q.size(), 32'd0);
    chk("wrap_count", {31'b0, wrap_q.size() >= 2}, 32'd1);
    if (wrap_q.size() >= 2) begin
      chk("wrap_first", wrap_q[0], 32'hFFFF_FFFC);
      chk("wrap_second", wrap_q[1], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
